// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control FSM and its timebase datapath.
// Pause is folded into MODE_IDLE because both hold the count.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_1X,
        MODE_10X,
        MODE_CLEAR
    } sw_mode_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

endpackage

// File: rtl/stopwatch_timebase_if.sv
// FSM status in, BCD time and event pulses out.
interface stopwatch_timebase_if;

    logic       run_1x;
    logic       run_10x;
    logic       pause;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       tick;
    logic       rollover;

    modport master (
        output run_1x, run_10x, pause, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, tick, rollover
    );

    modport slave (
        input  run_1x, run_10x, pause, clear,
        output sec_ones, sec_tens, min_ones, min_tens, tick, rollover
    );

endinterface

// File: rtl/stopwatch_timebase_bcd_digit.sv
// One BCD digit wrapping at MAX; carry is combinational so the cascade ripples in one edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit == MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = inc && (r_digit == MAX);

endmodule

// File: rtl/stopwatch_timebase.sv
// Elapsed-time counter MM:SS driven by the stopwatch FSM status, with a 1x/10x prescaler.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned PRESC_W  = $clog2(TICK_DIV)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    stopwatch_timebase_if.slave  bus
);

    sw_mode_t           w_mode;
    logic [PRESC_W-1:0] w_term;
    logic               w_active;
    logic               w_inc;
    logic               w_clr;
    logic [PRESC_W-1:0] r_presc;
    logic               r_tick;
    logic               r_rollover;
    logic               w_c_so, w_c_st, w_c_mo, w_c_mt;
    logic [3:0]         w_so, w_st, w_mo, w_mt;

    always_comb begin
        w_mode = MODE_IDLE;
        if (bus.clear)        w_mode = MODE_CLEAR;
        else if (bus.pause)   w_mode = MODE_IDLE;
        else if (bus.run_10x) w_mode = MODE_10X;
        else if (bus.run_1x)  w_mode = MODE_1X;
    end

    assign w_term   = (w_mode == MODE_10X) ? PRESC_W'(TICK_DIV / 10 - 1) : PRESC_W'(TICK_DIV - 1);
    assign w_active = (w_mode == MODE_1X) || (w_mode == MODE_10X);
    // >= lets a 1x->10x switch with a large prescaler value fire immediately
    assign w_inc    = w_active && (r_presc >= w_term);
    assign w_clr    = (w_mode == MODE_CLEAR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_presc    <= '0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_tick     <= w_inc;
            r_rollover <= w_c_mt;
            if (w_clr || w_inc) begin
                r_presc <= '0;
            end else if (w_active) begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    bcd_digit #(.MAX(BCD_MAX)) u_sec_ones (
        .clk(clk), .n_rst(n_rst), .clr(w_clr), .inc(w_inc),  .digit(w_so), .carry(w_c_so)
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .n_rst(n_rst), .clr(w_clr), .inc(w_c_so), .digit(w_st), .carry(w_c_st)
    );
    bcd_digit #(.MAX(BCD_MAX)) u_min_ones (
        .clk(clk), .n_rst(n_rst), .clr(w_clr), .inc(w_c_st), .digit(w_mo), .carry(w_c_mo)
    );
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .n_rst(n_rst), .clr(w_clr), .inc(w_c_mo), .digit(w_mt), .carry(w_c_mt)
    );

    assign bus.sec_ones = w_so;
    assign bus.sec_tens = w_st;
    assign bus.min_ones = w_mo;
    assign bus.min_tens = w_mt;
    assign bus.tick     = r_tick;
    assign bus.rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with an elapsed-seconds reference model.
module tb_stopwatch_timebase;

    localparam int unsigned DIV = 10;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    stopwatch_timebase_if bus ();

    stopwatch_timebase #(.TICK_DIV(DIV)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference: total elapsed seconds modulo one hour plus prescaler position
    int m_cnt = 0;
    int m_presc = 0;
    bit m_tick = 1'b0;
    bit m_roll = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_cnt <= 0; m_presc <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
        end else if (bus.clear) begin
            m_cnt <= 0; m_presc <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
        end else if (bus.pause || !(bus.run_1x || bus.run_10x)) begin
            m_tick <= 1'b0; m_roll <= 1'b0;
        end else if (m_presc >= (bus.run_10x ? int'(DIV / 10) - 1 : int'(DIV) - 1)) begin
            m_presc <= 0;
            m_tick  <= 1'b1;
            m_cnt   <= (m_cnt + 1) % 3600;
            m_roll  <= (m_cnt == 3599);
        end else begin
            m_presc <= m_presc + 1;
            m_tick  <= 1'b0;
            m_roll  <= 1'b0;
        end
    end

    function automatic logic [17:0] pack(int mt, int mo, int st, int so, bit t, bit r);
        return {4'(mt), 4'(mo), 4'(st), 4'(so), t, r};
    endfunction

    function automatic logic [17:0] model_vec();
        int mins = m_cnt / 60;
        int secs = m_cnt % 60;
        return pack(mins / 10, mins % 10, secs / 10, secs % 10, m_tick, m_roll);
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.tick, bus.rollover};
    endfunction

    task automatic check(string name, logic [17:0] act, logic [17:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h%0h:%0h%0h tick=%0b roll=%0b, expected %0h%0h:%0h%0h tick=%0b roll=%0b",
                     name, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("cycle", dut_vec(), model_vec());
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(bit r1, bit r10, bit p, bit c);
        bus.run_1x = r1; bus.run_10x = r10; bus.pause = p; bus.clear = c;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        step(2);
        chk_en = 1'b1;
        check("reset", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        step(1);
        n_rst = 1'b1;

        // 1x: first tick on the 10th edge, 00:05 after 50 edges
        drive(1, 0, 0, 0);
        step(9);
        check("1x_pre_tick", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        step(1);
        check("1x_first_tick", dut_vec(), pack(0, 0, 0, 1, 1, 0));
        step(40);
        check("1x_50_edges", dut_vec(), pack(0, 0, 0, 5, 1, 0));

        // Reach 00:07 with prescaler at 4, pause, resume
        step(24);
        check("pre_pause", dut_vec(), pack(0, 0, 0, 7, 0, 0));
        drive(1, 0, 1, 0);
        step(20);
        check("paused_hold", dut_vec(), pack(0, 0, 0, 7, 0, 0));
        drive(1, 0, 0, 0);
        step(5);
        check("resume_no_tick", dut_vec(), pack(0, 0, 0, 7, 0, 0));
        step(1);
        check("resume_tick", dut_vec(), pack(0, 0, 0, 8, 1, 0));

        // 1x with prescaler at 7, switch to 10x
        step(7);
        drive(1, 1, 0, 0);
        step(1);
        check("switch_10x_tick", dut_vec(), pack(0, 0, 0, 9, 1, 0));
        step(1);
        check("10x_every_cycle", dut_vec(), pack(0, 0, 1, 0, 1, 0));

        // Clear, then 600 edges at 10x
        drive(0, 1, 0, 1);
        step(1);
        check("clear", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0);
        step(600);
        check("10x_600", dut_vec(), pack(1, 0, 0, 0, 1, 0));

        // Up to 59:59 then rollover
        step(2999);
        check("at_5959", dut_vec(), pack(5, 9, 5, 9, 1, 0));
        step(1);
        check("rollover", dut_vec(), pack(0, 0, 0, 0, 1, 1));
        step(1);
        check("post_rollover", dut_vec(), pack(0, 0, 0, 1, 1, 0));

        // 12:34 then clear wins over run_1x
        step(753);
        check("at_1234", dut_vec(), pack(1, 2, 3, 4, 1, 0));
        drive(1, 0, 0, 1);
        step(1);
        check("clear_over_run", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        drive(1, 0, 0, 0);
        step(9);
        check("clear_presc0", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        step(1);
        check("clear_first_tick", dut_vec(), pack(0, 0, 0, 1, 1, 0));

        // Asynchronous reset mid-period
        step(3);
        #2 n_rst = 1'b0;
        #1 check("async_reset", dut_vec(), pack(0, 0, 0, 0, 0, 0));
        step(2);
        n_rst = 1'b1;
        step(12);
        check("after_reset", dut_vec(), pack(0, 0, 0, 1, 0, 0));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
Downstream datapath stage of the stopwatch control FSM. It consumes the FSM's run/pause/clear status outputs and turns them into an elapsed-time count. The count is kept as four BCD digits, MM:SS, ranging 00:00 to 59:59. A shared prescaler runs at either the 1x or 10x rate, depending on which run mode the FSM reports. The BCD digits drive the display stage.

Parameters:
TICK_DIV, 1000, clk cycles per count increment in 1x mode; must be a multiple of 10 and >= 10; 10x mode uses TICK_DIV/10.
PRESC_W, $clog2(TICK_DIV), prescaler counter width.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
run_1x  input  1  FSM status: running at normal rate.
run_10x  input  1  FSM status: running at 10x rate.
pause  input  1  FSM status: paused, hold count.
clear  input  1  FSM status: cleared, zero count.
sec_ones  output  4  BCD seconds units, 0-9.
sec_tens  output  4  BCD seconds tens, 0-5.
min_ones  output  4  BCD minutes units, 0-9.
min_tens  output  4  BCD minutes tens, 0-5.
tick  output  1  one-cycle pulse on the edge where the count increments.
rollover  output  1  one-cycle pulse when 59:59 wraps to 00:00; coincident with tick.

Behaviour:
- Reset:
  - One clock, clk; reset n_rst is asynchronous and active-low.
  - While n_rst=0, all digits, prescaler, tick and rollover are 0.
- Mode decode uses strict priority: clear > pause > run_10x > run_1x > idle.
  - Illegal combinations resolve by this priority; no error is flagged.
- Clear: synchronous. On the next edge, prescaler and all digits go to 0, and tick and rollover go to 0.
- Pause and idle (no input asserted): prescaler and digits hold their value; tick = 0.
- Active (run_1x or run_10x winning):
  - Terminal T = TICK_DIV-1 in 1x, TICK_DIV/10-1 in 10x.
  - Each edge: if presc >= T, then presc <= 0, tick <= 1, and the count increments.
  - Otherwise presc <= presc+1 and tick <= 0.
  - The >= comparison makes a 1x->10x switch with presc above the new T fire on the next edge; no other special handling.
  - 10x->1x continues from the current presc value.
- Increment latency: from presc=0 with the mode held, the first increment and tick occur on the (T+1)th active edge.
  - Example: TICK_DIV=10, 1x: 10 edges. 10x: 1 edge, i.e. tick every cycle.
- Resume from pause continues from the held presc value, with no restart of the partial period.
- Tick and digit update are registered together: digits show the new value in the same cycle tick is high.
- BCD cascade, single-cycle ripple within the increment edge:
  - sec_ones wraps 9->0 and carries into sec_tens.
  - sec_tens wraps 5->0 and carries into min_ones.
  - min_ones wraps 9->0 and carries into min_tens.
  - min_tens wraps 5->0 and asserts rollover.
- Rollover: 59:59 + increment gives 00:00 with tick=1 and rollover=1 for one cycle. Counting continues afterwards; there is no saturation.
- Reset mid-operation: async clear of all state regardless of mode. After deassertion the block obeys the inputs from the next edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef enum logic [1:0] {MODE_IDLE, MODE_1X, MODE_10X, MODE_CLEAR} sw_mode_t, including pause-as-idle hold semantics.
  - Constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, BCD_MAX=9.
  - The FSM and timebase share this package.
- Sub-module bcd_digit, instantiated four times, has:
  - parameter MAX;
  - inputs clk, n_rst, clr, inc;
  - outputs digit[3:0] and carry, where carry = inc && digit==MAX.
- Mode decode and prescaler stay in the top.

Test Plan:
1. Reset then run_1x=1 held, TICK_DIV=10 -> presc counts 0..9; sec_ones=1 and tick=1 on the 10th edge; sec_ones=5 after 50 edges.
2. run_10x=1 held, TICK_DIV=10 -> tick every cycle; after 600 edges the count reads 10:00 (min_tens=1, others 0).
3. Count to 00:07 at 1x with presc=4, then pause=1 for 20 cycles, then run_1x=1 -> digits and presc hold during pause; next tick comes 6 edges after resume.
4. 1x with presc=7, switch to run_10x (T=0) -> tick on the next edge, presc=0, then tick every cycle.
5. Preload to 59:59 via 10x run (3599 ticks), then one more tick -> 00:00 with tick=1 and rollover=1 for exactly one cycle; rollover=0 on the next tick.
6. Mid-count (12:34): assert clear together with run_1x -> 00:00, presc=0 on the next edge. Then n_rst pulse low mid-period while running -> all outputs 0 immediately, without waiting for clk.
